// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: register file geometry and the
// hardwired $zero index.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dec5x32.sv
// 5-to-32 one-hot decoder with enable, built as four 3-to-8 cells whose
// enables come from a 2-to-4 decode of the two index MSBs.
module dec5x32
  import mips_pkg::*;
(
  input  logic        en,
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);

  logic [3:0] grp_en;

  always_comb begin
    grp_en = '0;
    if (en) begin
      grp_en[idx[4:3]] = 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cell
    logic [7:0] cell_out;

    always_comb begin
      cell_out = '0;
      if (grp_en[g]) begin
        cell_out[idx[2:0]] = 1'b1;
      end
    end

    assign onehot[g*8 +: 8] = cell_out;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32 x 32 register file with write-through bypass on both read ports and a
// single-bit-per-register pending-write scoreboard for ID hazard detection.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              busy_a,
  output logic              busy_b
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] set_sel;

  dec5x32 u_wr_dec (
    .en     (wr_en),
    .idx    (wr_addr),
    .onehot (wr_sel)
  );

  dec5x32 u_set_dec (
    .en     (issue_valid),
    .idx    (issue_dst),
    .onehot (set_sel)
  );

  // Storage and scoreboard update; a same-edge issue beats a retirement
  // because the issue belongs to the younger instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      regs[0] <= '0;
      busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= wr_data;
        end
        busy[i] <= set_sel[i] | (busy[i] & ~wr_sel[i]);
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    if (addr == REG_ZERO) begin
      return '0;
    end else if (wr_en && (wr_addr == addr)) begin
      return wr_data;
    end
    return stored;
  endfunction

  function automatic logic busy_port(
    input logic [ADDR_W-1:0] addr,
    input logic              pending
  );
    return pending && !(wr_en && (wr_addr == addr));
  endfunction

  // Combinational ID-side read: same-cycle WB retirement bypasses data and
  // masks busy so both views stay consistent.
  always_comb begin
    rd_data_a = read_port(rd_addr_a, regs[rd_addr_a]);
    rd_data_b = read_port(rd_addr_b, regs[rd_addr_b]);
    busy_a    = busy_port(rd_addr_a, busy[rd_addr_a]);
    busy_b    = busy_port(rd_addr_b, busy[rd_addr_b]);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: stimulus pushes expected read/busy values computed from
// an array-based reference model; a monitor pops and compares each cycle.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        busy_a;
  logic        busy_b;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_b   (rd_data_b),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .busy_a      (busy_a),
    .busy_b      (busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic        ba;
    logic        bb;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  int checks = 0;
  int passed = 0;
  bit stim_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input logic we, input logic [4:0] wa);
    return m_busy[a] && !(we && wa == a);
  endfunction

  // One clock of stimulus: drive at negedge, predict outputs, advance model.
  task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                     input logic iv, input logic [4:0] id);
    exp_t e;
    @(negedge clk);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; issue_valid = iv; issue_dst = id;
    e.da = exp_read(ra, we, wa, wd);
    e.db = exp_read(rb, we, wa, wd);
    e.ba = exp_busy(ra, we, wa);
    e.bb = exp_busy(rb, we, wa);
    exp_q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 0;
      end
    end else begin
      if (we && wa != 0) begin
        m_reg[wa] = wd;
        m_busy[wa] = 0;
      end
      if (iv && id != 0) m_busy[id] = 1;
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data_a", rd_data_a, e.da);
        chk("rd_data_b", rd_data_b, e.db);
        chk("busy_a", {31'd0, busy_a}, {31'd0, e.ba});
        chk("busy_b", {31'd0, busy_b}, {31'd0, e.bb});
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 0;
    end
    reset = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_addr_a = 0; rd_addr_b = 0; issue_valid = 0; issue_dst = 0;
    repeat (2) @(posedge clk);

    // Reset with garbage pending
    cyc(0, 1, 5, 32'hDEADBEEF, 5, 6, 0, 0);
    cyc(0, 0, 0, 0, 5, 6, 1, 5);
    cyc(1, 1, 6, 32'h11112222, 5, 6, 1, 6);
    cyc(0, 0, 0, 0, 5, 6, 0, 0);

    // Write then read, and same-cycle bypass
    cyc(0, 1, 7, 32'h12345678, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 7, 8, 0, 0);
    cyc(0, 1, 8, 32'hA5A5A5A5, 7, 8, 0, 0);
    cyc(0, 0, 0, 0, 8, 8, 0, 0);

    // Zero register
    cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard lifecycle
    cyc(0, 0, 0, 0, 3, 0, 1, 3);
    repeat (3) cyc(0, 0, 0, 0, 3, 0, 0, 0);
    cyc(0, 1, 3, 32'h55, 3, 3, 0, 0);
    cyc(0, 0, 0, 0, 3, 3, 0, 0);

    // Simultaneous set and clear
    cyc(0, 0, 0, 0, 4, 0, 1, 4);
    cyc(0, 1, 4, 32'h99, 4, 0, 1, 4);
    cyc(0, 0, 0, 0, 4, 4, 0, 0);

    // Dual-port contention
    cyc(0, 1, 9, 32'hCAFEF00D, 9, 9, 1, 9);
    cyc(0, 0, 0, 0, 9, 9, 0, 0);
    cyc(0, 1, 9, 32'h0BADCAFE, 9, 9, 0, 0);
    cyc(0, 0, 0, 0, 9, 9, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
          rnd_addr(), rnd_addr(),
          1'($urandom_range(0, 1)), rnd_addr());
    end

    @(negedge clk);
    reset = 0; wr_en = 0; issue_valid = 0;
    repeat (2) @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    stim_done = 1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    if (!stim_done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
